// File: rtl/fetch_queue.sv
`timescale 1ns/1ps
`default_nettype none
// +------------------------------------------------------------------------+
// | fetch_queue                                                            |
// | Instruction fetch buffer: issues imem reads, queues {PC, instr} and    |
// | hands the head entry to decode over a valid/ready handshake.           |
// | Rev 1.0                                                                |
// +------------------------------------------------------------------------+
module fetch_queue #(
   parameter int ADDR_WIDTH  = 16,
   parameter int INSTR_WIDTH = 32,
   parameter int DEPTH       = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [ADDR_WIDTH-1:0]  PCounterF,
   input  logic                   flush,
   output logic                   imem_req,
   output logic [ADDR_WIDTH-1:0]  imem_addr,
   input  logic [INSTR_WIDTH-1:0] imem_rdata,
   output logic                   stallF,
   output logic                   validD,
   input  logic                   readyD,
   output logic [INSTR_WIDTH-1:0] InstrD,
   output logic [ADDR_WIDTH-1:0]  PCD,
   output logic [ADDR_WIDTH-1:0]  PCPlus4D
);

   localparam int c_ptr_w = $clog2(DEPTH);
   localparam logic [c_ptr_w+1:0] c_depth = (c_ptr_w+2)'(DEPTH);

   logic [ADDR_WIDTH-1:0]  r_pc_mem    [DEPTH];
   logic [INSTR_WIDTH-1:0] r_instr_mem [DEPTH];
   logic [c_ptr_w-1:0]     r_rd_ptr;
   logic [c_ptr_w-1:0]     r_wr_ptr;
   logic [c_ptr_w:0]       r_count;
   logic                   r_pending;
   logic [ADDR_WIDTH-1:0]  r_pending_pc;

   logic [c_ptr_w+1:0]     w_occ;
   logic                   w_push;
   logic                   w_pop;

   // An outstanding fetch holds a slot, so stored entries plus in-flight
   // must never exceed DEPTH; a same-cycle pop is deliberately not credited.
   assign w_occ     = {1'b0, r_count} + {{(c_ptr_w+1){1'b0}}, r_pending};
   assign stallF    = !flush && (w_occ >= c_depth);
   assign imem_req  = !rst && !flush && !stallF;
   assign imem_addr = PCounterF;

   assign validD    = (r_count != '0) && !flush;
   assign w_push    = r_pending && !flush;
   assign w_pop     = validD && readyD;

   assign InstrD    = r_instr_mem[r_rd_ptr];
   assign PCD       = r_pc_mem[r_rd_ptr];
   assign PCPlus4D  = PCD + ADDR_WIDTH'(4);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_rd_ptr  <= '0;
         r_wr_ptr  <= '0;
         r_count   <= '0;
         r_pending <= 1'b0;
      end else if (flush) begin
         r_rd_ptr  <= '0;
         r_wr_ptr  <= '0;
         r_count   <= '0;
         r_pending <= 1'b0;
      end else begin
         r_pending <= imem_req;
         if (w_push) r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + (c_ptr_w+1)'(1);
            2'b01:   r_count <= r_count - (c_ptr_w+1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Datapath registers carry no reset; validity is tracked by r_count/r_pending.
   always_ff @(posedge clk) begin
      if (imem_req) r_pending_pc <= PCounterF;
      if (w_push && !rst) begin
         r_pc_mem[r_wr_ptr]    <= r_pending_pc;
         r_instr_mem[r_wr_ptr] <= imem_rdata;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue.sv
`timescale 1ns/1ps
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_fetch_queue                                                         |
// | Table-driven bench with PC-counter/imem model and in-order scoreboard. |
// | Rev 1.0                                                                |
// +------------------------------------------------------------------------+
module tb_fetch_queue;

   localparam int AW = 16;
   localparam int IW = 32;

   logic          clk = 1'b0;
   logic          rst;
   logic          flush;
   logic          readyD;
   logic [AW-1:0] PCounterF;
   logic [IW-1:0] imem_rdata;
   logic          imem_req;
   logic [AW-1:0] imem_addr;
   logic          stallF;
   logic          validD;
   logic [IW-1:0] InstrD;
   logic [AW-1:0] PCD;
   logic [AW-1:0] PCPlus4D;

   fetch_queue #(.ADDR_WIDTH(AW), .INSTR_WIDTH(IW), .DEPTH(4)) dut (
      .clk        (clk),
      .rst        (rst),
      .PCounterF  (PCounterF),
      .flush      (flush),
      .imem_req   (imem_req),
      .imem_addr  (imem_addr),
      .imem_rdata (imem_rdata),
      .stallF     (stallF),
      .validD     (validD),
      .readyD     (readyD),
      .InstrD     (InstrD),
      .PCD        (PCD),
      .PCPlus4D   (PCPlus4D)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic          rs;
      logic          f;
      logic          r;
      logic [AW-1:0] tgt;
      logic          ck;
      logic          ev;
      logic          es;
      logic          eq;
   } vec_t;

   vec_t          vt[$];
   logic [AW-1:0] sb[$];
   int            n_tests = 0;
   int            n_fail  = 0;
   logic [AW-1:0] pc;
   logic          s_req;
   logic          s_stall;
   logic [AW-1:0] s_addr;
   logic          seen_wrap = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic vec_t mk(input logic rs, f, r, input logic [AW-1:0] tgt,
                               input logic ck, ev, es, eq);
      vec_t v;
      v.rs = rs; v.f = f; v.r = r; v.tgt = tgt;
      v.ck = ck; v.ev = ev; v.es = es; v.eq = eq;
      return v;
   endfunction

   task automatic apply_row(input vec_t v);
      logic [AW-1:0] exp_pc;
      logic [AW-1:0] exp_nxt;
      rst    = v.rs;
      flush  = v.f;
      readyD = v.r;
      @(negedge clk);
      if (v.ck) begin
         chk("validD",    32'(validD),    32'(v.ev));
         chk("stallF",    32'(stallF),    32'(v.es));
         chk("imem_req",  32'(imem_req),  32'(v.eq));
         chk("imem_addr", 32'(imem_addr), 32'(PCounterF));
      end
      if (validD && readyD) begin
         if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL pop_empty: got PCD %h expected no entry", PCD);
         end else begin
            exp_pc  = sb.pop_front();
            exp_nxt = exp_pc + 16'd4;
            chk("PCD",      32'(PCD),      32'(exp_pc));
            chk("InstrD",   InstrD,        32'h100 + 32'(exp_pc));
            chk("PCPlus4D", 32'(PCPlus4D), 32'(exp_nxt));
            if (exp_pc == 16'hFFFC) begin
               seen_wrap = 1'b1;
               chk("PCPlus4D_wrap", 32'(PCPlus4D), 32'h0);
            end
         end
      end
      if (imem_req) sb.push_back(PCounterF);
      if (flush || rst) sb.delete();
      s_req   = imem_req;
      s_addr  = PCounterF;
      s_stall = stallF;
      @(posedge clk);
      #1;
      imem_rdata = s_req ? (32'h100 + 32'(s_addr)) : 32'hDEAD_BEEF;
      if (v.rs)          pc = '0;
      else if (v.f)      pc = v.tgt;
      else if (!s_stall) pc = pc + 16'd4;
      PCounterF = pc;
   endtask

   initial begin
      rst        = 1'b1;
      flush      = 1'b0;
      readyD     = 1'b0;
      pc         = '0;
      PCounterF  = '0;
      imem_rdata = '0;

      // reset state
      vt.push_back(mk(1,0,0,16'h0, 1, 0,0,0));
      vt.push_back(mk(1,0,0,16'h0, 1, 0,0,0));
      // fill with readyD=0, then drain
      vt.push_back(mk(0,0,0,16'h0, 1, 0,0,1));
      vt.push_back(mk(0,0,0,16'h0, 1, 0,0,1));
      vt.push_back(mk(0,0,0,16'h0, 1, 1,0,1));
      vt.push_back(mk(0,0,0,16'h0, 1, 1,0,1));
      vt.push_back(mk(0,0,0,16'h0, 1, 1,1,0));
      vt.push_back(mk(0,0,0,16'h0, 1, 1,1,0));
      vt.push_back(mk(0,0,1,16'h0, 1, 1,1,0));
      vt.push_back(mk(0,0,1,16'h0, 1, 1,0,1));
      for (int i = 0; i < 7; i++) vt.push_back(mk(0,0,1,16'h0, 1, 1,0,1));
      // reset, then sustained throughput with readyD=1 (pointer wrap)
      vt.push_back(mk(1,0,0,16'h0, 0, 0,0,0));
      vt.push_back(mk(0,0,1,16'h0, 1, 0,0,1));
      vt.push_back(mk(0,0,1,16'h0, 1, 0,0,1));
      for (int i = 0; i < 20; i++) vt.push_back(mk(0,0,1,16'h0, 1, 1,0,1));
      // flush coinciding with a returning response and a pop
      vt.push_back(mk(0,1,1,16'h0080, 1, 0,0,0));
      vt.push_back(mk(0,0,1,16'h0, 1, 0,0,1));
      vt.push_back(mk(0,0,1,16'h0, 1, 0,0,1));
      for (int i = 0; i < 4; i++) vt.push_back(mk(0,0,1,16'h0, 1, 1,0,1));
      // full queue plus in-flight fetch, then flush to 0x40
      vt.push_back(mk(1,0,0,16'h0, 0, 0,0,0));
      vt.push_back(mk(0,0,0,16'h0, 1, 0,0,1));
      vt.push_back(mk(0,0,0,16'h0, 1, 0,0,1));
      vt.push_back(mk(0,0,0,16'h0, 1, 1,0,1));
      vt.push_back(mk(0,0,0,16'h0, 1, 1,0,1));
      vt.push_back(mk(0,1,0,16'h0040, 1, 0,0,0));
      vt.push_back(mk(0,0,0,16'h0, 1, 0,0,1));
      vt.push_back(mk(0,0,0,16'h0, 1, 0,0,1));
      for (int i = 0; i < 3; i++) vt.push_back(mk(0,0,1,16'h0, 1, 1,0,1));
      // address wrap through 0xFFFC
      vt.push_back(mk(0,1,1,16'hFFF4, 1, 0,0,0));
      vt.push_back(mk(0,0,1,16'h0, 1, 0,0,1));
      vt.push_back(mk(0,0,1,16'h0, 1, 0,0,1));
      for (int i = 0; i < 6; i++) vt.push_back(mk(0,0,1,16'h0, 1, 1,0,1));
      // reset with 3 entries plus a pending fetch
      vt.push_back(mk(0,0,0,16'h0, 1, 1,0,1));
      vt.push_back(mk(0,0,0,16'h0, 1, 1,0,1));
      vt.push_back(mk(1,0,0,16'h0, 0, 0,0,0));
      vt.push_back(mk(0,0,0,16'h0, 1, 0,0,1));
      vt.push_back(mk(0,0,0,16'h0, 1, 0,0,1));
      for (int i = 0; i < 4; i++) vt.push_back(mk(0,0,1,16'h0, 1, 1,0,1));

      foreach (vt[i]) apply_row(vt[i]);

      chk("wrap_seen", 32'(seen_wrap), 32'h1);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
